stopwatch_bcd: RTL

STOPWATCH_BCD -- requirements
Module: stopwatch_bcd

---
 rtl/stopwatch_bcd.sv | 93 +++++++++
 1 files changed

// File: rtl/stopwatch_bcd.sv
// stopwatch_bcd: 24-hour BCD stopwatch counting synchronised tick_in edges.
// Run/pause is toggled by start_stop; clear zeroes the time and returns to IDLE.
module stopwatch_bcd #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clock_in,
   input  logic       reset,
   input  logic       tick_in,
   input  logic       start_stop,
   input  logic       clear,
   output logic [3:0] sec_ones,
   output logic [2:0] sec_tens,
   output logic [3:0] min_ones,
   output logic [2:0] min_tens,
   output logic [3:0] hr_ones,
   output logic [1:0] hr_tens,
   output logic       running,
   output logic       rollover
);
   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] RUN    = 2'd1;
   localparam logic [1:0] PAUSED = 2'd2;

   logic [SYNC_STAGES-1:0] sync;
   logic                   hist;
   logic                   tick_pulse;
   logic [1:0]             state;
   logic [1:0]             state_n;
   logic                   count;
   logic                   c1, c2, c3, c4, day_end;
   logic [3:0]             sec_ones_n, min_ones_n, hr_ones_n;
   logic [2:0]             sec_tens_n, min_tens_n;
   logic [1:0]             hr_tens_n;

   assign tick_pulse = sync[SYNC_STAGES-1] & ~hist;

   always_comb begin
      state_n = clear ? IDLE : !start_stop ? state : (state == RUN) ? PAUSED : RUN;
      count   = !clear && state == RUN && tick_pulse;
   end

   // Full carry chain computed combinationally so every digit moves on one edge.
   always_comb begin
      c1         = sec_ones == 4'd9;
      c2         = c1 && sec_tens == 3'd5;
      c3         = c2 && min_ones == 4'd9;
      c4         = c3 && min_tens == 3'd5;
      day_end    = c4 && hr_tens == 2'd2 && hr_ones == 4'd3;
      sec_ones_n = c1 ? 4'd0 : sec_ones + 4'd1;
      sec_tens_n = !c1 ? sec_tens : c2 ? 3'd0 : sec_tens + 3'd1;
      min_ones_n = !c2 ? min_ones : c3 ? 4'd0 : min_ones + 4'd1;
      min_tens_n = !c3 ? min_tens : c4 ? 3'd0 : min_tens + 3'd1;
      hr_ones_n  = day_end ? 4'd0 : !c4 ? hr_ones : (hr_ones == 4'd9) ? 4'd0 : hr_ones + 4'd1;
      hr_tens_n  = day_end ? 2'd0 : (c4 && hr_ones == 4'd9) ? hr_tens + 2'd1 : hr_tens;
   end

   always_ff @(posedge clock_in or posedge reset) begin
      if (reset) begin
         sync     <= '0;
         hist     <= 1'b0;
         state    <= IDLE;
         running  <= 1'b0;
         rollover <= 1'b0;
         sec_ones <= 4'd0;
         sec_tens <= 3'd0;
         min_ones <= 4'd0;
         min_tens <= 3'd0;
         hr_ones  <= 4'd0;
         hr_tens  <= 2'd0;
      end else begin
         sync     <= {sync[SYNC_STAGES-2:0], tick_in};
         hist     <= sync[SYNC_STAGES-1];
         state    <= state_n;
         running  <= state_n == RUN;
         rollover <= count && day_end;
         if (clear) begin
            sec_ones <= 4'd0;
            sec_tens <= 3'd0;
            min_ones <= 4'd0;
            min_tens <= 3'd0;
            hr_ones  <= 4'd0;
            hr_tens  <= 2'd0;
         end else if (count) begin
            sec_ones <= sec_ones_n;
            sec_tens <= sec_tens_n;
            min_ones <= min_ones_n;
            min_tens <= min_tens_n;
            hr_ones  <= hr_ones_n;
            hr_tens  <= hr_tens_n;
         end
      end
   end
endmodule
